fifo_ram_param: RTL

Parametrised synchronous FIFO built around a dual-port RAM (one write port, one read port), generalising the fixed 8x12b memory to configurable width and depth. Internal pointers replace external write/read addresses. Occupancy, full/empty and programmable almost-full/almost-empty flags let producer/consumer logic in the datapath stall without tracking addresses. One clock domain; sits between a data source and any consumer that needs buffering.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/ram_dp_param.sv | 45 ++++
 rtl/fifo_ram_param.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg: shared defaults, count-width helper and reset values for the
//           fifo_ram_param FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int DEF_DATA_W = 12;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_AF_TH  = 6;
   localparam int DEF_AE_TH  = 2;

   localparam logic RST_VALID = 1'b0;
   localparam logic RST_ERR   = 1'b0;

   // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
   function automatic int count_w(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dp_param.sv
// ============================================================================
// ram_dp_param: DEPTH x DATA_W dual-port RAM, synchronous write port and
//               registered read port (read-before-write on address collision).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_dp_param
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Only the output register is reset; the array contents are left as-is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_ram_param.sv
// ============================================================================
// fifo_ram_param: parametrised synchronous FIFO over a dual-port RAM with
//                 occupancy, full/empty and almost-full/almost-empty flags.
//                 Optional sticky error flags: define FIFO_ERR_FLAGS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_ram_param
   import fifo_pkg::*;
#(
   parameter int DATA_W          = DEF_DATA_W,
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int ALMOST_FULL_TH  = DEF_AF_TH,
   parameter int ALMOST_EMPTY_TH = DEF_AE_TH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      push,
   input  logic                      pop,
   output logic [DATA_W-1:0]         data_out,
   output logic                      valid_out,
   output logic [count_w(ADDR_W)-1:0] count,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic                      err_overflow,
   output logic                      err_underflow
);

   localparam int CW    = count_w(ADDR_W);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF_TH = CW'(ALMOST_FULL_TH);
   localparam logic [CW-1:0] CNT_AE_TH = CW'(ALMOST_EMPTY_TH);

   logic [ADDR_W-1:0] wp;
   logic [ADDR_W-1:0] rp;
   logic              push_acc;
   logic              pop_acc;

   // A push into a full FIFO is allowed when a pop frees a slot the same cycle.
   assign pop_acc  = pop && !empty;
   assign push_acc = push && (!full || pop_acc);

   assign full         = (count == CNT_DEPTH);
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_AF_TH);
   assign almost_empty = (count <= CNT_AE_TH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         valid_out <= RST_VALID;
      end else begin
         valid_out <= pop_acc;
         if (push_acc) begin
            wp <= wp + ADDR_W'(1);
         end
         if (pop_acc) begin
            rp <= rp + ADDR_W'(1);
         end
         case ({push_acc, pop_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_overflow  <= RST_ERR;
         err_underflow <= RST_ERR;
      end else begin
         if (push && !push_acc) begin
            err_overflow <= 1'b1;
         end
         if (pop && empty) begin
            err_underflow <= 1'b1;
         end
      end
   end
`else
   assign err_overflow  = RST_ERR;
   assign err_underflow = RST_ERR;
`endif

   ram_dp_param #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (push_acc),
      .waddr (wp),
      .wdata (data_in),
      .re    (pop_acc),
      .raddr (rp),
      .rdata (data_out)
   );

endmodule

`default_nettype wire
